// File: rtl/vram_arb_pkg.sv
// Shared types and default sizes for the single-port work-RAM arbiter.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_VID  = 2'd2
  } gnt_e;

  localparam int unsigned C_ADDR_BITS = 15;
  localparam int unsigned C_DATA_BITS = 8;
  localparam int unsigned C_MAX_WAIT  = 4;
  localparam int unsigned C_WAIT_BITS = 4;

endpackage

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port synchronous RAM between the CPU bus and the video
// fetch unit: CPU first, unless a pending video read has been deferred too long.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned P_addr_bits = C_ADDR_BITS,
  parameter int unsigned P_data_bits = C_DATA_BITS,
  parameter int unsigned P_max_wait  = C_MAX_WAIT
) (
  input  logic                   I_clock,
  input  logic                   I_reset,
  input  logic [P_addr_bits-1:0] I_cpu_addr,
  input  logic                   I_cpu_rden,
  input  logic                   I_cpu_wren,
  input  logic [P_data_bits-1:0] I_cpu_data,
  output logic [P_data_bits-1:0] O_cpu_data,
  output logic                   O_cpu_ready,
  input  logic [P_addr_bits-1:0] I_vid_addr,
  input  logic                   I_vid_rden,
  output logic                   O_vid_busy,
  output logic [P_data_bits-1:0] O_vid_data,
  output logic                   O_vid_valid,
  output logic [P_addr_bits-1:0] O_ram_addr,
  output logic                   O_ram_rden,
  output logic                   O_ram_wren,
  output logic [P_data_bits-1:0] O_ram_data,
  input  logic [P_data_bits-1:0] I_ram_data
);

  localparam logic [C_WAIT_BITS-1:0] L_MAX_WAIT = C_WAIT_BITS'(P_max_wait);

  logic                   w_cpu_req;
  gnt_e                   w_gnt;

  logic                   r_pending;
  logic [P_addr_bits-1:0] r_vid_addr;
  logic [C_WAIT_BITS-1:0] r_wait_cnt;
  logic                   r_vid_valid_p1;
  logic                   r_cpu_rd_p1;
  logic [P_data_bits-1:0] r_vid_hold;
  logic [P_data_bits-1:0] r_cpu_hold;
  logic [P_addr_bits-1:0] r_ram_addr;
  logic [P_data_bits-1:0] r_ram_data;

  assign w_cpu_req = I_cpu_rden | I_cpu_wren;

  // Grant is forced to none while reset is held so the RAM strobes stay low.
  always_comb begin
    w_gnt = GNT_NONE;
    if (!I_reset) begin
      w_gnt = GNT_NONE;
    end else if (r_pending && (!w_cpu_req || (r_wait_cnt == L_MAX_WAIT))) begin
      w_gnt = GNT_VID;
    end else if (w_cpu_req) begin
      w_gnt = GNT_CPU;
    end
  end

  always_comb begin
    O_ram_rden = 1'b0;
    O_ram_wren = 1'b0;
    O_ram_addr = r_ram_addr;
    O_ram_data = r_ram_data;
    case (w_gnt)
      GNT_VID: begin
        O_ram_rden = 1'b1;
        O_ram_addr = r_vid_addr;
      end
      GNT_CPU: begin
        O_ram_rden = ~I_cpu_wren;
        O_ram_wren = I_cpu_wren;
        O_ram_addr = I_cpu_addr;
        O_ram_data = I_cpu_data;
      end
      default: ;
    endcase
  end

  assign O_cpu_ready = ~(w_cpu_req & (w_gnt == GNT_VID));
  assign O_vid_busy  = r_pending;
  assign O_vid_valid = r_vid_valid_p1;
  // Read data passes straight through in the cycle it arrives, then is held.
  assign O_vid_data  = r_vid_valid_p1 ? I_ram_data : r_vid_hold;
  assign O_cpu_data  = r_cpu_rd_p1    ? I_ram_data : r_cpu_hold;

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_pending      <= 1'b0;
      r_vid_addr     <= '0;
      r_wait_cnt     <= '0;
      r_vid_valid_p1 <= 1'b0;
      r_cpu_rd_p1    <= 1'b0;
      r_vid_hold     <= '0;
      r_cpu_hold     <= '0;
      r_ram_addr     <= '0;
      r_ram_data     <= '0;
    end else begin
      if (w_gnt == GNT_VID) begin
        r_pending <= 1'b0;
      end else if (!r_pending && I_vid_rden) begin
        r_pending  <= 1'b1;
        r_vid_addr <= I_vid_addr;
      end

      if (!r_pending || (w_gnt == GNT_VID)) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != L_MAX_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      // Read-return stage: tag which requester the RAM output belongs to.
      r_vid_valid_p1 <= (w_gnt == GNT_VID);
      r_cpu_rd_p1    <= (w_gnt == GNT_CPU) && !I_cpu_wren;
      if (r_vid_valid_p1) r_vid_hold <= I_ram_data;
      if (r_cpu_rd_p1)    r_cpu_hold <= I_ram_data;

      r_ram_addr <= O_ram_addr;
      r_ram_data <= O_ram_data;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and randomized bench for vram_arbiter against a cycle-level reference model.
module tb_vram_arbiter;

  localparam int AW   = 15;
  localparam int DW   = 8;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          I_reset = 1'b0;
  logic [AW-1:0] I_cpu_addr = '0;
  logic          I_cpu_rden = 1'b0;
  logic          I_cpu_wren = 1'b0;
  logic [DW-1:0] I_cpu_data = '0;
  logic [DW-1:0] O_cpu_data;
  logic          O_cpu_ready;
  logic [AW-1:0] I_vid_addr = '0;
  logic          I_vid_rden = 1'b0;
  logic          O_vid_busy;
  logic [DW-1:0] O_vid_data;
  logic          O_vid_valid;
  logic [AW-1:0] O_ram_addr;
  logic          O_ram_rden;
  logic          O_ram_wren;
  logic [DW-1:0] O_ram_data;
  logic [DW-1:0] ram_q = '0;

  vram_arbiter #(.P_addr_bits(AW), .P_data_bits(DW), .P_max_wait(MAXW)) dut (
    .I_clock(clk), .I_reset(I_reset),
    .I_cpu_addr(I_cpu_addr), .I_cpu_rden(I_cpu_rden), .I_cpu_wren(I_cpu_wren),
    .I_cpu_data(I_cpu_data), .O_cpu_data(O_cpu_data), .O_cpu_ready(O_cpu_ready),
    .I_vid_addr(I_vid_addr), .I_vid_rden(I_vid_rden), .O_vid_busy(O_vid_busy),
    .O_vid_data(O_vid_data), .O_vid_valid(O_vid_valid),
    .O_ram_addr(O_ram_addr), .O_ram_rden(O_ram_rden), .O_ram_wren(O_ram_wren),
    .O_ram_data(O_ram_data), .I_ram_data(ram_q)
  );

  always #5 clk = ~clk;

  // Environment RAM driven by the DUT: synchronous, one-cycle read latency.
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (O_ram_wren) env_mem[O_ram_addr] <= O_ram_data;
    if (O_ram_rden) ram_q <= env_mem[O_ram_addr];
  end

  // Reference state, expressed as request age and expected memory contents.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            n_vvalid = 0;
  logic          m_pend;
  logic [AW-1:0] m_vaddr;
  int            m_cap;
  logic          m_vvalid, m_crd;
  logic [DW-1:0] m_vread, m_vhold, m_cread, m_chold, m_data;
  logic [AW-1:0] m_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_vaddr = '0; m_cap = 0;
    m_vvalid = 1'b0; m_crd = 1'b0;
    m_vread = '0; m_vhold = '0; m_cread = '0; m_chold = '0;
    m_addr = '0; m_data = '0;
  endtask

  task automatic step(input logic rd, input logic wr, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd, input logic vr, input logic [AW-1:0] va,
                      input logic rstn);
    logic          req, vg, cg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    I_reset = rstn; I_cpu_rden = rd; I_cpu_wren = wr; I_cpu_addr = ca;
    I_cpu_data = cd; I_vid_rden = vr; I_vid_addr = va;
    if (!rstn) model_reset();
    @(negedge clk);
    req = rd | wr;
    vg  = rstn && m_pend && (!req || ((cyc - m_cap) >= MAXW));
    cg  = rstn && !vg && req;
    ea  = vg ? m_vaddr : (cg ? ca : m_addr);
    ed  = cg ? cd : m_data;
    chk("ram_rden",  32'(O_ram_rden),  32'(vg || (cg && !wr)));
    chk("ram_wren",  32'(O_ram_wren),  32'(cg && wr));
    chk("ram_addr",  32'(O_ram_addr),  32'(ea));
    chk("ram_data",  32'(O_ram_data),  32'(ed));
    chk("cpu_ready", 32'(O_cpu_ready), 32'(!(req && vg)));
    chk("vid_busy",  32'(O_vid_busy),  32'(m_pend));
    chk("vid_valid", 32'(O_vid_valid), 32'(m_vvalid));
    chk("vid_data",  32'(O_vid_data),  32'(m_vvalid ? m_vread : m_vhold));
    chk("cpu_data",  32'(O_cpu_data),  32'(m_crd ? m_cread : m_chold));
    if (O_vid_valid) n_vvalid++;
    @(posedge clk);
    if (rstn) begin
      if (m_vvalid) m_vhold = m_vread;
      if (m_crd)    m_chold = m_cread;
      m_vvalid = vg;
      if (vg) m_vread = ref_mem[m_vaddr];
      m_crd = cg && !wr;
      if (m_crd) m_cread = ref_mem[ca];
      if (cg && wr) ref_mem[ca] = cd;
      if (vg) m_pend = 1'b0;
      else if (!m_pend && vr) begin
        m_pend = 1'b1; m_vaddr = va; m_cap = cyc + 1;
      end
      m_addr = ea; m_data = ed;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    int base;
    for (int i = 0; i < (1 << AW); i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[15'h6000] = 8'h41; ref_mem[15'h6000] = 8'h41;
    model_reset();

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);

    // Idle CPU, single video read of 0x6000.
    base = n_vvalid;
    idle(2);
    step(1'b0, 1'b0, '0, '0, 1'b1, 15'h6000, 1'b1);
    idle(4);
    chk("t1_vvalid_count", 32'(n_vvalid - base), 32'd1);
    chk("t1_vdata_held", 32'(O_vid_data), 32'h41);

    // CPU reads every cycle, video must preempt after the maximum wait.
    base = n_vvalid;
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b0, 15'(16'h0100 + i), '0, (i == 2), 15'h6000, 1'b1);
    idle(2);
    chk("t2_vvalid_count", 32'(n_vvalid - base), 32'd1);

    // CPU write then read back.
    step(1'b0, 1'b1, 15'h0010, 8'h5A, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 15'h0010, 8'h00, 1'b0, '0, 1'b1);
    idle(3);
    chk("t3_cpu_hold", 32'(O_cpu_data), 32'h5A);

    // Second video request while busy is dropped.
    base = n_vvalid;
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 15'h0020, '0, (i == 0) || (i == 2), (i == 0) ? 15'h0123 : 15'h0456, 1'b1);
    idle(3);
    chk("t4_vvalid_count", 32'(n_vvalid - base), 32'd1);
    chk("t4_vdata_first", 32'(O_vid_data), 32'(ref_mem[15'h0123]));

    // Reset right after a video grant discards the read.
    base = n_vvalid;
    step(1'b0, 1'b0, '0, '0, 1'b1, 15'h0200, 1'b1);
    idle(1);
    step(1'b1, 1'b0, 15'h0300, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    idle(3);
    chk("t5_vvalid_count", 32'(n_vvalid - base), 32'd0);
    chk("t5_vdata_zero", 32'(O_vid_data), 32'd0);

    // Read and write strobes together act as a write.
    step(1'b1, 1'b1, 15'h0040, 8'hC3, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 15'h0040, 8'h00, 1'b0, '0, 1'b1);
    idle(2);
    chk("t6_rw_write", 32'(O_cpu_data), 32'hC3);

    // Randomized traffic over a small address window to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      logic rd, wr, vr, rstn;
      rd   = ($urandom_range(0, 99) < 55);
      wr   = ($urandom_range(0, 99) < 20);
      vr   = ($urandom_range(0, 99) < 35);
      rstn = ($urandom_range(0, 199) != 0);
      step(rd, wr, 15'($urandom_range(0, 63)), DW'($urandom), vr,
           15'($urandom_range(0, 63)), rstn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous work RAM between the CPU core bus and the video fetch unit.
- Replaces the dual-port memory arrangement, so the design fits targets with only single-port block RAM.
- The CPU has priority by default. A video read that has waited too long takes priority over the CPU, and the CPU is stalled through its ready line.
- The block sits between the core/cart decode, the video block and the RAM.

Parameters:
P_addr_bits, 15, RAM address width
P_data_bits, 8, RAM data width
P_max_wait, 4, cycles a pending video read may be deferred before it preempts the CPU (1..15)

Ports:
I_clock  in  1  system clock
I_reset  in  1  asynchronous, active-low reset
I_cpu_addr  in  P_addr_bits  CPU address
I_cpu_rden  in  1  CPU read strobe (already phy2- and chip-select-gated)
I_cpu_wren  in  1  CPU write strobe
I_cpu_data  in  P_data_bits  CPU write data
O_cpu_data  out  P_data_bits  CPU read data
O_cpu_ready  out  1  low = CPU access not performed this cycle; the CPU holds its request
I_vid_addr  in  P_addr_bits  video fetch address
I_vid_rden  in  1  video read request, single-cycle pulse
O_vid_busy  out  1  video request pending; new video requests are ignored
O_vid_data  out  P_data_bits  video read data
O_vid_valid  out  1  one-cycle pulse, O_vid_data valid
O_ram_addr  out  P_addr_bits  RAM address
O_ram_rden  out  1  RAM read enable
O_ram_wren  out  1  RAM write enable
O_ram_data  out  P_data_bits  RAM write data
I_ram_data  in  P_data_bits  RAM read data, valid the cycle after O_ram_rden

Behaviour:
- RAM timing: synchronous, one-cycle read latency.
- Grant is combinational each cycle from the registered state.
- cpu_req = I_cpu_rden | I_cpu_wren. If both are asserted, the request is treated as a write.
- Video capture: when I_vid_rden=1 and pending=0, latch I_vid_addr and set pending. While pending=1, I_vid_rden is ignored (no queueing). O_vid_busy = pending.
- Grant rule: video is granted if pending and (!cpu_req or wait_cnt==P_max_wait). Otherwise cpu_req means CPU is granted. Otherwise no grant.
- Video grant drives the RAM with latched address and rden=1, and clears pending at the clock edge.
- CPU grant drives the RAM with I_cpu_addr/data, rden or wren.
- No grant: O_ram_rden=O_ram_wren=0, and O_ram_addr holds its last value.
- O_cpu_ready = !(cpu_req & video granted). It is 1 whenever the CPU is idle.
- wait_cnt: cleared when pending is 0 or video is granted. It increments when pending and not granted, saturating at P_max_wait.
- Video latency:
  - Request at cycle n gives pending at n+1; the earliest grant is n+1.
  - O_vid_valid pulses at grant+1.
  - O_vid_data is registered from I_ram_data at grant+1 and then held.
- CPU read latency:
  - Granted at cycle n: O_cpu_data equals I_ram_data during n+1 (pass-through).
  - O_cpu_data is captured into a hold register at the end of n+1 and holds until the next granted CPU read completes.
- Worst-case CPU stall: one cycle per video request. A video request waits at most P_max_wait+1 cycles after capture.
- A video request pulse arriving in the same cycle pending is cleared is ignored (busy still high).
- Reset (I_reset low, any time):
  - pending=0, wait_cnt=0, hold registers=0.
  - O_vid_valid=0, O_vid_data=0, O_cpu_data=0.
  - O_ram_rden=O_ram_wren=0 (forced), O_ram_addr=0, O_ram_data=0, O_cpu_ready=1.
  - A read in flight is discarded, and no O_vid_valid is issued after reset.

Decomposition:
- Package vram_arb_pkg: grant enum (GNT_NONE, GNT_CPU, GNT_VID) and default width constants.
- No sub-module: the wait counter and capture register are inline.

Test Plan:
- CPU idle, video read of 0x6000 (RAM holds 0x41) at cycle 2 -> O_ram_rden at cycle 3, O_vid_valid=1 with O_vid_data=0x41 at cycle 4, O_vid_busy high only in cycle 3.
- CPU reads every cycle from cycle 0, video read at cycle 2, P_max_wait=4 -> CPU granted cycles 3-6 with wait_cnt 0..3 at cycles 3..6 (4 from cycle 7), video granted cycle 7 with O_cpu_ready=0 in cycle 7 only, O_vid_valid at cycle 8.
- CPU writes 0x5A to 0x0010, then reads 0x0010 -> O_ram_wren one cycle, O_cpu_data=0x5A the cycle after the read grant, held after.
- Second I_vid_rden while busy -> ignored, exactly one O_vid_valid, address of the first request used.
- I_reset asserted the cycle after a video grant -> no O_vid_valid, all outputs at reset values, O_cpu_ready=1.
- I_cpu_rden and I_cpu_wren both high -> RAM write only, O_ram_rden=0.
